ether_tx: RTL and testbench

- MII (4-bit) Ethernet transmit stage; mirror of the receive stage on the same host command bus.
- Host loads frame bytes as 32-bit words into an internal 512x32 buffer, sets the byte length, then issues SEND.
- Block emits preamble/SFD, data, optional zero padding and CRC-32 FCS on MII TX, holds inter-frame gap, then acknowledges.

---
 rtl/ether_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_ether_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_tx.sv
// MII (4-bit) Ethernet transmit stage: host fills a 512x32 frame buffer and issues SEND;
// the block emits preamble/SFD, data, optional zero padding and CRC-32 FCS, then holds the IFG.
module ether_tx #(
   parameter int PAD_EN           = 1,
   parameter int IFG_NIBBLES      = 24,
   parameter int PREAMBLE_NIBBLES = 15
) (
   input  logic        etx_clk,
   input  logic        etx_rst,
   input  logic        etx_cs,
   input  logic [3:0]  etx_cmd,
   input  logic [31:0] etx_din,
   output logic        etx_ready,
   output logic [3:0]  etx_txd,
   output logic        etx_en,
   output logic        etx_err,
   output logic [7:0]  etx_debug
);

   typedef enum logic [3:0] {
      IDLE     = 4'd1,
      FETCH    = 4'd2,
      PREAMBLE = 4'd3,
      DATA     = 4'd4,
      PAD      = 4'd5,
      FCS      = 4'd6,
      IFG      = 4'd7,
      ACK      = 4'd8
   } state_t;

   localparam logic        PAD_ON   = (PAD_EN != 0);
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_NIBBLES);
   localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

   state_t      state, state_n;
   logic        cs_prev;
   logic [10:0] size, size_n;
   logic [8:0]  wptr, wptr_n;
   logic [8:0]  raddr, raddr_n;
   logic [31:0] rdata;
   logic [31:0] word, word_n;
   logic [31:0] crc, crc_n;
   logic [15:0] cnt, cnt_n;
   logic [10:0] byte_cnt, byte_n;
   logic        nib, nib_n;
   logic        ready, ready_n;
   logic [3:0]  txd, txd_n;
   logic        en, en_n;
   logic        we;
   logic        accept;
   logic        last_byte;
   logic        pad_needed;
   logic [7:0]  cur_byte;
   logic [3:0]  data_nib;

   logic [31:0] mem [0:511];

   // Reflected CRC-32 advanced by one nibble, low bit first.
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c ^ {28'd0, d};
      for (int i = 0; i < 4; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign accept     = etx_cs & ~cs_prev & (state == IDLE);
   assign last_byte  = (({1'b0, byte_cnt} + 12'd1) == {1'b0, size});
   assign pad_needed = PAD_ON && (size < 11'd60);
   assign data_nib   = nib ? cur_byte[7:4] : cur_byte[3:0];

   always_comb begin
      cur_byte = word[7:0];
      case (byte_cnt[1:0])
         2'd1:    cur_byte = word[15:8];
         2'd2:    cur_byte = word[23:16];
         2'd3:    cur_byte = word[31:24];
         default: cur_byte = word[7:0];
      endcase
   end

   // Next-state and datapath; MII outputs are computed here and registered one cycle later.
   always_comb begin
      state_n = state;
      size_n  = size;
      wptr_n  = wptr;
      raddr_n = raddr;
      word_n  = word;
      crc_n   = crc;
      cnt_n   = cnt;
      byte_n  = byte_cnt;
      nib_n   = nib;
      ready_n = ready;
      txd_n   = 4'd0;
      en_n    = 1'b0;
      we      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (etx_cmd)
                  4'd1: begin
                     size_n  = etx_din[10:0];
                     wptr_n  = 9'd0;
                     state_n = ACK;
                  end
                  4'd2: begin
                     we      = 1'b1;
                     wptr_n  = wptr + 9'd1;
                     state_n = ACK;
                  end
                  4'd3: begin
                     crc_n   = 32'hFFFFFFFF;
                     cnt_n   = 16'd0;
                     byte_n  = 11'd0;
                     nib_n   = 1'b0;
                     raddr_n = 9'd0;
                     state_n = (size == 11'd0 && !PAD_ON) ? ACK : FETCH;
                  end
                  default: ;
               endcase
            end
         end
         FETCH: begin
            cnt_n   = 16'd0;
            state_n = PREAMBLE;
         end
         PREAMBLE: begin
            en_n = 1'b1;
            if (cnt == PRE_LAST) begin
               txd_n   = 4'hD;
               word_n  = rdata;
               raddr_n = raddr + 9'd1;
               state_n = (size != 11'd0) ? DATA : PAD;
            end else begin
               txd_n = 4'h5;
               cnt_n = cnt + 16'd1;
            end
         end
         DATA: begin
            en_n  = 1'b1;
            txd_n = data_nib;
            crc_n = crc_nib(crc, data_nib);
            nib_n = ~nib;
            if (nib) begin
               byte_n = byte_cnt + 11'd1;
               // The next word was prefetched eight nibbles ago, so there is no gap here.
               if (byte_cnt[1:0] == 2'd3) begin
                  word_n  = rdata;
                  raddr_n = raddr + 9'd1;
               end
               if (last_byte) begin
                  cnt_n   = 16'd0;
                  state_n = pad_needed ? PAD : FCS;
               end
            end
         end
         PAD: begin
            en_n  = 1'b1;
            crc_n = crc_nib(crc, 4'd0);
            nib_n = ~nib;
            if (nib) begin
               byte_n = byte_cnt + 11'd1;
               if (byte_cnt == 11'd59) begin
                  cnt_n   = 16'd0;
                  state_n = FCS;
               end
            end
         end
         FCS: begin
            en_n  = 1'b1;
            txd_n = ~crc[3:0];
            crc_n = {4'hF, crc[31:4]};
            cnt_n = cnt + 16'd1;
            if (cnt == 16'd7) begin
               cnt_n   = 16'd0;
               state_n = IFG;
            end
         end
         IFG: begin
            cnt_n = cnt + 16'd1;
            if (cnt == IFG_LAST) begin
               state_n = ACK;
            end
         end
         ACK: begin
            ready_n = ~ready;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge etx_clk or posedge etx_rst) begin
      if (etx_rst) begin
         state    <= IDLE;
         cs_prev  <= 1'b0;
         size     <= 11'd0;
         wptr     <= 9'd0;
         raddr    <= 9'd0;
         word     <= 32'd0;
         crc      <= 32'hFFFFFFFF;
         cnt      <= 16'd0;
         byte_cnt <= 11'd0;
         nib      <= 1'b0;
         ready    <= 1'b0;
         txd      <= 4'd0;
         en       <= 1'b0;
      end else begin
         state    <= state_n;
         cs_prev  <= etx_cs;
         size     <= size_n;
         wptr     <= wptr_n;
         raddr    <= raddr_n;
         word     <= word_n;
         crc      <= crc_n;
         cnt      <= cnt_n;
         byte_cnt <= byte_n;
         nib      <= nib_n;
         ready    <= ready_n;
         txd      <= txd_n;
         en       <= en_n;
      end
   end

   // Frame buffer survives reset; read port is synchronous with one cycle of latency.
   always_ff @(posedge etx_clk) begin
      if (we) begin
         mem[wptr] <= etx_din;
      end
      rdata <= mem[raddr];
   end

   assign etx_ready = ready;
   assign etx_txd   = txd;
   assign etx_en    = en;
   assign etx_err   = 1'b0;
   assign etx_debug = {byte_cnt[3:0], state};

endmodule

// File: tb/tb_ether_tx.sv
// Directed bench for ether_tx: one unpadded instance and one padded instance share the
// command bus; captured MII frames are compared with hand vectors and a bytewise CRC model.
module tb_ether_tx;

   logic        clk;
   logic        rst;
   logic        cs0, cs1;
   logic [3:0]  cmd;
   logic [31:0] din;
   logic        ready0, ready1;
   logic [3:0]  txd0, txd1;
   logic        en0, en1;
   logic        err0, err1;
   logic [7:0]  debug0, debug1;

   int checks = 0;
   int errors = 0;
   int tog0 = 0, tog1 = 0, en_cycles0 = 0;
   logic last0 = 1'b0, last1 = 1'b0;

   logic [3:0] frame[$];
   logic [3:0] exp_frame[$];
   logic [7:0] exp_bytes[$];
   int en_len, gap, rise_dly;
   int t0, t1, e0;

   ether_tx #(.PAD_EN(0), .IFG_NIBBLES(24), .PREAMBLE_NIBBLES(15)) dut0 (
      .etx_clk(clk), .etx_rst(rst), .etx_cs(cs0), .etx_cmd(cmd), .etx_din(din),
      .etx_ready(ready0), .etx_txd(txd0), .etx_en(en0), .etx_err(err0), .etx_debug(debug0)
   );

   ether_tx #(.PAD_EN(1), .IFG_NIBBLES(24), .PREAMBLE_NIBBLES(15)) dut1 (
      .etx_clk(clk), .etx_rst(rst), .etx_cs(cs1), .etx_cmd(cmd), .etx_din(din),
      .etx_ready(ready1), .etx_txd(txd1), .etx_en(en1), .etx_err(err1), .etx_debug(debug1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ready toggle and TX_EN activity counters, resynchronised while reset is held.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         last0 = ready0;
         last1 = ready1;
      end else begin
         if (ready0 !== last0) begin
            tog0++;
            last0 = ready0;
         end
         if (ready1 !== last1) begin
            tog1++;
            last1 = ready1;
         end
         if (en0 === 1'b1) en_cycles0++;
      end
   end

   function automatic logic sel_en(input int w);
      return (w == 0) ? en0 : en1;
   endfunction

   function automatic logic [3:0] sel_txd(input int w);
      return (w == 0) ? txd0 : txd1;
   endfunction

   function automatic logic sel_ready(input int w);
      return (w == 0) ? ready0 : ready1;
   endfunction

   function automatic logic [31:0] crcModel(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'd0, q[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int which, input logic [3:0] c, input logic [31:0] d);
      @(negedge clk);
      cmd = c;
      din = d;
      if (which == 0) cs0 = 1'b1;
      else cs1 = 1'b1;
      @(negedge clk);
      cs0 = 1'b0;
      cs1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic buildExpected(input int pad);
      logic [7:0]  b[$];
      logic [31:0] c;
      b = exp_bytes;
      if (pad != 0) begin
         while (b.size() < 60) b.push_back(8'h00);
      end
      exp_frame.delete();
      repeat (15) exp_frame.push_back(4'h5);
      exp_frame.push_back(4'hD);
      foreach (b[i]) begin
         exp_frame.push_back(b[i][3:0]);
         exp_frame.push_back(b[i][7:4]);
      end
      c = crcModel(b);
      for (int k = 0; k < 8; k++) exp_frame.push_back(c[4*k +: 4]);
   endtask

   // Starts right after SEND has been applied; records every nibble while TX_EN is high,
   // then counts cycles from TX_EN falling to the ready toggle.
   task automatic captureFrame(input int which);
      int   t;
      logic r0;
      frame.delete();
      en_len = 0;
      gap    = 0;
      t      = 0;
      while (sel_en(which) !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      rise_dly = t;
      checkOutput("en_rise_timeout", 64'(t >= 400), 64'd0);
      while (sel_en(which) === 1'b1 && en_len < 4000) begin
         frame.push_back(sel_txd(which));
         en_len++;
         @(negedge clk);
      end
      checkOutput("txd_idle_after_frame", sel_txd(which), 4'd0);
      r0 = sel_ready(which);
      while (sel_ready(which) === r0 && gap < 1000) begin
         @(negedge clk);
         gap++;
      end
      checkOutput("ack_timeout", 64'(gap >= 1000), 64'd0);
   endtask

   task automatic compareFrame(input string name);
      checkOutput({name, "_frame_len"}, frame.size(), exp_frame.size());
      for (int i = 0; i < exp_frame.size(); i++) begin
         if (i < frame.size()) begin
            checkOutput($sformatf("%s_nib%0d", name, i), frame[i], exp_frame[i]);
         end
      end
   endtask

   initial begin
      logic [3:0] fcs_hand[8];
      fcs_hand = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
      rst = 1'b1;
      cs0 = 1'b0;
      cs1 = 1'b0;
      cmd = 4'd0;
      din = 32'd0;
      repeat (3) @(negedge clk);

      checkOutput("rst_ready", ready0, 1'b0);
      checkOutput("rst_en", en0, 1'b0);
      checkOutput("rst_txd", txd0, 4'd0);
      checkOutput("rst_err", err0, 1'b0);
      checkOutput("rst_state0", debug0[3:0], 4'd1);
      checkOutput("rst_state1", debug1[3:0], 4'd1);
      rst = 1'b0;
      @(negedge clk);

      // "123456789" on the unpadded instance
      t0 = tog0;
      applyStimulus(0, 4'd2, 32'h34333231);
      applyStimulus(0, 4'd2, 32'h38373635);
      applyStimulus(0, 4'd2, 32'h00000039);
      checkOutput("load_putdata_toggles", tog0 - t0, 3);
      applyStimulus(0, 4'd1, 32'd9);
      checkOutput("load_setsize_toggle", tog0 - t0, 4);
      t0 = tog0;
      applyStimulus(0, 4'd7, 32'd0);
      checkOutput("unknown_cmd_no_toggle", tog0 - t0, 0);
      checkOutput("unknown_cmd_idle", debug0[3:0], 4'd1);

      exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      buildExpected(0);
      t0 = tog0;
      applyStimulus(0, 4'd3, 32'd0);
      captureFrame(0);
      checkOutput("f9_en_len", en_len, 42);
      checkOutput("f9_en_delay", rise_dly, 1);
      checkOutput("f9_ifg", gap, 24);
      checkOutput("f9_send_toggle", tog0 - t0, 1);
      compareFrame("f9");
      for (int k = 0; k < 8; k++) begin
         if (34 + k < frame.size()) checkOutput($sformatf("f9_fcs%0d", k), frame[34+k], fcs_hand[k]);
      end

      // A SETSIZE edge while the frame is in DATA must be ignored
      t0 = tog0;
      applyStimulus(0, 4'd3, 32'd0);
      fork
         captureFrame(0);
         begin
            repeat (20) @(negedge clk);
            checkOutput("busy_in_data", debug0[3:0], 4'd4);
            cmd = 4'd1;
            din = 32'd100;
            cs0 = 1'b1;
            @(negedge clk);
            cs0 = 1'b0;
         end
      join
      checkOutput("busy_en_len", en_len, 42);
      checkOutput("busy_toggle", tog0 - t0, 1);
      compareFrame("busy");

      t0 = tog0;
      applyStimulus(0, 4'd3, 32'd0);
      captureFrame(0);
      checkOutput("resend_en_len", en_len, 42);
      checkOutput("resend_toggle", tog0 - t0, 1);
      compareFrame("resend");

      // Reset while idle clears ready and size but keeps the buffer
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("idle_rst_ready", ready0, 1'b0);
      checkOutput("idle_rst_state", debug0[3:0], 4'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      t0 = tog0;
      e0 = en_cycles0;
      applyStimulus(0, 4'd3, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("size0_nopad_toggle", tog0 - t0, 1);
      checkOutput("size0_nopad_no_en", en_cycles0 - e0, 0);

      // Reset in the middle of a frame
      applyStimulus(0, 4'd1, 32'd9);
      t0 = tog0;
      applyStimulus(0, 4'd3, 32'd0);
      repeat (25) @(negedge clk);
      checkOutput("midframe_en_before", en0, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("midframe_en_drop", en0, 1'b0);
      checkOutput("midframe_txd_drop", txd0, 4'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("midframe_no_toggle", tog0 - t0, 0);
      checkOutput("midframe_state_idle", debug0[3:0], 4'd1);

      applyStimulus(0, 4'd1, 32'd9);
      t0 = tog0;
      applyStimulus(0, 4'd3, 32'd0);
      captureFrame(0);
      checkOutput("after_rst_en_len", en_len, 42);
      checkOutput("after_rst_toggle", tog0 - t0, 1);
      compareFrame("after_rst");

      // Padded instance: 4 x 0xFF then 56 zero bytes
      applyStimulus(1, 4'd1, 32'd4);
      applyStimulus(1, 4'd2, 32'hFFFFFFFF);
      exp_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      buildExpected(1);
      t1 = tog1;
      applyStimulus(1, 4'd3, 32'd0);
      captureFrame(1);
      checkOutput("pad4_en_len", en_len, 144);
      checkOutput("pad4_ifg", gap, 24);
      checkOutput("pad4_toggle", tog1 - t1, 1);
      compareFrame("pad4");

      applyStimulus(1, 4'd1, 32'd0);
      exp_bytes.delete();
      buildExpected(1);
      applyStimulus(1, 4'd3, 32'd0);
      captureFrame(1);
      checkOutput("pad0_en_len", en_len, 144);
      compareFrame("pad0");

      // Write pointer wraps: word 512 lands in buf[0]
      t0 = tog0;
      applyStimulus(0, 4'd1, 32'd0);
      for (int k = 0; k < 513; k++) applyStimulus(0, 4'd2, 32'(k));
      checkOutput("wrap_toggles", tog0 - t0, 514);
      applyStimulus(0, 4'd1, 32'd4);
      exp_bytes = '{8'h00, 8'h02, 8'h00, 8'h00};
      buildExpected(0);
      applyStimulus(0, 4'd3, 32'd0);
      captureFrame(0);
      checkOutput("wrap_en_len", en_len, 32);
      compareFrame("wrap");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
